// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
//
// Purpose : Shared constants for the synchronous FIFO slice. This holds the
//           read-latency values for the two storage output modes and the
//           default thresholds for the almost-full / almost-empty flags.
//
// Contents:
//   READ_LATENCY_NO_REG     - cycles from accepted pop to RVALID_O, no RAM output register
//   READ_LATENCY_OUT_REG    - cycles from accepted pop to RVALID_O, with RAM output register
//   ALMOST_EMPTY_TH_DEFAULT - default occupancy at or below which ALMOST_EMPTY_O asserts
//   ALMOST_FULL_MARGIN      - distance from full used for the default almost-full level
//   almostFullDefault()     - default almost-full threshold for a given address width
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

    localparam int READ_LATENCY_NO_REG     = 1;
    localparam int READ_LATENCY_OUT_REG    = 2;

    localparam int ALMOST_EMPTY_TH_DEFAULT = 4;
    localparam int ALMOST_FULL_MARGIN      = 4;

    // The default almost-full level sits a fixed margin below the depth.
    function automatic int almostFullDefault(input int addrWidth);
        return (1 << addrWidth) - ALMOST_FULL_MARGIN;
    endfunction

endpackage

// File: rtl/sync_fifo_sdpram.sv
// -----------------------------------------------------------------------------
// SDPRAM_SINGLECLK
//
// Purpose : Simple dual-port RAM with a single clock. It has one write port
//           and one synchronous read port. The read is "read-first": if a
//           word is written and read at the same address on the same edge,
//           the read returns the old contents. The array has no reset, so
//           its contents survive a FIFO reset.
//
// Parameters:
//   DATA_WIDTH - word width in bits
//   ADDR_WIDTH - address width; depth = 2^ADDR_WIDTH
//   OUTPUT_REG - "TRUE" adds a second register stage after the read register
//
// Ports:
//   CLK_I     in   clock, rising edge
//   WENABLE_I in   write strobe
//   WADDR_I   in   write address
//   WDATA_I   in   write data
//   RENABLE_I in   read strobe; loads the read register
//   RADDR_I   in   read address
//   RDATA_O   out  read data, 1 cycle (or 2 cycles with OUTPUT_REG) after RENABLE_I
// -----------------------------------------------------------------------------
module SDPRAM_SINGLECLK #(
    parameter int    DATA_WIDTH = 8,
    parameter int    ADDR_WIDTH = 9,
    parameter string OUTPUT_REG = "FALSE"
) (
    input  logic                  CLK_I,
    input  logic                  WENABLE_I,
    input  logic [ADDR_WIDTH-1:0] WADDR_I,
    input  logic [DATA_WIDTH-1:0] WDATA_I,
    input  logic                  RENABLE_I,
    input  logic [ADDR_WIDTH-1:0] RADDR_I,
    output logic [DATA_WIDTH-1:0] RDATA_O
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] readStage_q;

    // Write port and synchronous read port share one edge. The read samples
    // the array before the non-blocking write lands, which gives read-first
    // behaviour. A full FIFO doing push+pop relies on this, because both
    // pointers then address the same word.
    always_ff @(posedge CLK_I) begin
        if (WENABLE_I) begin
            mem[WADDR_I] <= WDATA_I;
        end
        if (RENABLE_I) begin
            readStage_q <= mem[RADDR_I];
        end
    end

    generate
        if (OUTPUT_REG == "TRUE") begin : gOutReg
            logic [DATA_WIDTH-1:0] outStage_q;

            // The extra output stage runs freely. The FIFO's valid pipeline
            // tracks which cycle carries a real word.
            always_ff @(posedge CLK_I) begin
                outStage_q <= readStage_q;
            end

            assign RDATA_O = outStage_q;
        end else begin : gNoReg
            assign RDATA_O = readStage_q;
        end
    endgenerate

endmodule

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//
// Purpose : Single-clock FIFO built around SDPRAM_SINGLECLK. It provides
//           registered full, empty and almost flags, an occupancy counter,
//           and sticky overflow and underflow indicators. Popped data comes
//           out with a fixed latency of 1 cycle, or 2 cycles when OUTPUT_REG
//           is "TRUE". RDATA_O holds the last delivered word between pops.
//
// Parameters:
//   DATA_WIDTH      - word width in bits
//   ADDR_WIDTH      - log2 of depth
//   OUTPUT_REG      - "TRUE" inserts a RAM output register stage
//   ALMOST_FULL_TH  - ALMOST_FULL_O asserts when count >= this value
//   ALMOST_EMPTY_TH - ALMOST_EMPTY_O asserts when count <= this value
//
// Ports:
//   CLK_I          in   clock, rising edge
//   NRST_I         in   asynchronous active-low reset
//   WENABLE_I      in   push request
//   WDATA_I        in   push data
//   RENABLE_I      in   pop request
//   RDATA_O        out  popped data (holds between pops)
//   RVALID_O       out  one-cycle strobe marking a delivered word
//   FULL_O         out  count == depth
//   EMPTY_O        out  count == 0
//   ALMOST_FULL_O  out  count >= ALMOST_FULL_TH
//   ALMOST_EMPTY_O out  count <= ALMOST_EMPTY_TH
//   COUNT_O        out  occupancy, 0..depth
//   OVERFLOW_O     out  sticky: a push was rejected
//   UNDERFLOW_O    out  sticky: a pop was rejected
// -----------------------------------------------------------------------------
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int    DATA_WIDTH      = 8,
    parameter int    ADDR_WIDTH      = 9,
    parameter string OUTPUT_REG      = "FALSE",
    parameter int    ALMOST_FULL_TH  = almostFullDefault(ADDR_WIDTH),
    parameter int    ALMOST_EMPTY_TH = ALMOST_EMPTY_TH_DEFAULT
) (
    input  logic                  CLK_I,
    input  logic                  NRST_I,
    input  logic                  WENABLE_I,
    input  logic [DATA_WIDTH-1:0] WDATA_I,
    input  logic                  RENABLE_I,
    output logic [DATA_WIDTH-1:0] RDATA_O,
    output logic                  RVALID_O,
    output logic                  FULL_O,
    output logic                  EMPTY_O,
    output logic                  ALMOST_FULL_O,
    output logic                  ALMOST_EMPTY_O,
    output logic [ADDR_WIDTH:0]   COUNT_O,
    output logic                  OVERFLOW_O,
    output logic                  UNDERFLOW_O
);

    localparam int CW      = ADDR_WIDTH + 1;
    localparam int LATENCY = (OUTPUT_REG == "TRUE") ? READ_LATENCY_OUT_REG
                                                    : READ_LATENCY_NO_REG;

    localparam logic [CW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [CW-1:0] AF_TH = CW'(ALMOST_FULL_TH);
    localparam logic [CW-1:0] AE_TH = CW'(ALMOST_EMPTY_TH);

    logic                  pushAccept;
    logic                  popAccept;
    logic [CW-1:0]         wptr_q, wptr_d;
    logic [CW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, empty_q, afull_q, aempty_q;
    logic                  overflow_q, underflow_q;
    logic [LATENCY-1:0]    valid_q, valid_d;
    logic [LATENCY:0]      validShift;
    logic [DATA_WIDTH-1:0] hold_q;
    logic [DATA_WIDTH-1:0] ramRdata;

    // Request qualification and next-state computation.
    // - A pop is never served from a push in the same cycle, so popAccept
    //   looks only at the registered empty flag.
    // - A push into a full FIFO is allowed only when a pop frees a slot on
    //   the same edge.
    // The pointers carry one extra MSB so that full and empty can be told
    // apart after a wrap.
    always_comb begin
        popAccept  = RENABLE_I && !empty_q;
        pushAccept = WENABLE_I && (!full_q || popAccept);

        wptr_d = pushAccept ? (wptr_q + CW'(1)) : wptr_q;
        rptr_d = popAccept  ? (rptr_q + CW'(1)) : rptr_q;

        count_d = count_q;
        if (pushAccept && !popAccept) begin
            count_d = count_q + CW'(1);
        end else if (popAccept && !pushAccept) begin
            count_d = count_q - CW'(1);
        end

        // Valid pipeline: the accepted pop enters at bit 0 and reaches the
        // top bit after LATENCY edges, in step with the RAM read path.
        validShift = {valid_q, popAccept};
        valid_d    = validShift[LATENCY-1:0];
    end

    // State registers.
    // - All flags come from the next count, so each flag is correct in the
    //   cycle right after the edge that caused it.
    // - The error flags are sticky until reset.
    // - Reset clears the valid pipeline, so a pop that is in flight when
    //   reset asserts never produces a strobe.
    always_ff @(posedge CLK_I or negedge NRST_I) begin
        if (!NRST_I) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            valid_q     <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            full_q      <= (count_d == DEPTH);
            empty_q     <= (count_d == '0);
            afull_q     <= (count_d >= AF_TH);
            aempty_q    <= (count_d <= AE_TH);
            overflow_q  <= overflow_q  | (WENABLE_I & ~pushAccept);
            underflow_q <= underflow_q | (RENABLE_I & ~popAccept);
            valid_q     <= valid_d;
        end
    end

    // Output hold register. The RAM read stages have no reset and may
    // change on cycles that carry no word. This register keeps the last
    // delivered word, and is zero after reset, so that RDATA_O is stable
    // while RVALID_O is low.
    always_ff @(posedge CLK_I or negedge NRST_I) begin
        if (!NRST_I) begin
            hold_q <= '0;
        end else if (valid_q[LATENCY-1]) begin
            hold_q <= ramRdata;
        end
    end

    SDPRAM_SINGLECLK #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .OUTPUT_REG (OUTPUT_REG)
    ) uRam (
        .CLK_I     (CLK_I),
        .WENABLE_I (pushAccept),
        .WADDR_I   (wptr_q[ADDR_WIDTH-1:0]),
        .WDATA_I   (WDATA_I),
        .RENABLE_I (popAccept),
        .RADDR_I   (rptr_q[ADDR_WIDTH-1:0]),
        .RDATA_O   (ramRdata)
    );

    assign RVALID_O       = valid_q[LATENCY-1];
    assign RDATA_O        = valid_q[LATENCY-1] ? ramRdata : hold_q;
    assign FULL_O         = full_q;
    assign EMPTY_O        = empty_q;
    assign ALMOST_FULL_O  = afull_q;
    assign ALMOST_EMPTY_O = aempty_q;
    assign COUNT_O        = count_q;
    assign OVERFLOW_O     = overflow_q;
    assign UNDERFLOW_O    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
//
// Purpose : Self-checking bench for sync_fifo. Two instances share the same
//           stimulus: dutA uses OUTPUT_REG="FALSE" and dutB uses
//           OUTPUT_REG="TRUE". Both use 8-bit data and a depth of 16.
//           Expected values come from a queue-based model of the FIFO rules
//           and from hand-computed vector tables.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       nrst;
    logic       wen;
    logic       ren;
    logic [7:0] wdata;

    logic [7:0] rdataA, rdataB;
    logic       rvalidA, rvalidB;
    logic       fullA, fullB, emptyA, emptyB;
    logic       afA, afB, aeA, aeB;
    logic [4:0] countA, countB;
    logic       ovfA, ovfB, unfA, unfB;

    int errors = 0;
    int checks = 0;

    // Reference model: the queue holds the FIFO contents in push order.
    logic [7:0] modelQ[$];
    bit         mOvf, mUnf;
    bit         pendValidB;
    logic [7:0] pendDataB;
    bit         expValidA, expValidB;
    logic [7:0] lastA, lastB;

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       re;
        int         expCount;
        bit         expEmpty;
        bit         expValid;
        logic [7:0] expData;
        bit         expUnf;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    sync_fifo #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .OUTPUT_REG ("FALSE")
    ) dutA (
        .CLK_I          (clk),
        .NRST_I         (nrst),
        .WENABLE_I      (wen),
        .WDATA_I        (wdata),
        .RENABLE_I      (ren),
        .RDATA_O        (rdataA),
        .RVALID_O       (rvalidA),
        .FULL_O         (fullA),
        .EMPTY_O        (emptyA),
        .ALMOST_FULL_O  (afA),
        .ALMOST_EMPTY_O (aeA),
        .COUNT_O        (countA),
        .OVERFLOW_O     (ovfA),
        .UNDERFLOW_O    (unfA)
    );

    sync_fifo #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .OUTPUT_REG ("TRUE")
    ) dutB (
        .CLK_I          (clk),
        .NRST_I         (nrst),
        .WENABLE_I      (wen),
        .WDATA_I        (wdata),
        .RENABLE_I      (ren),
        .RDATA_O        (rdataB),
        .RVALID_O       (rvalidB),
        .FULL_O         (fullB),
        .EMPTY_O        (emptyB),
        .ALMOST_FULL_O  (afB),
        .ALMOST_EMPTY_O (aeB),
        .COUNT_O        (countB),
        .OVERFLOW_O     (ovfB),
        .UNDERFLOW_O    (unfB)
    );

    task automatic cmp(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        modelQ.delete();
        mOvf       = 1'b0;
        mUnf       = 1'b0;
        pendValidB = 1'b0;
        pendDataB  = 8'd0;
        expValidA  = 1'b0;
        expValidB  = 1'b0;
        lastA      = 8'd0;
        lastB      = 8'd0;
    endtask

    // One clock edge of FIFO behaviour, written directly from the rules:
    // - A pop needs a non-empty FIFO.
    // - A push needs space, or a pop on the same edge.
    // - Rejected requests set the sticky flags.
    // - dutA shows the popped word after 1 edge, dutB after 2 edges.
    task automatic modelStep(input logic we, input logic [7:0] wd, input logic re);
        bit         popOk;
        bit         pushOk;
        logic [7:0] popped;
        popped = 8'd0;
        popOk  = re && (modelQ.size() != 0);
        pushOk = we && ((modelQ.size() < DEPTH) || popOk);
        if (we && !pushOk) mOvf = 1'b1;
        if (re && !popOk)  mUnf = 1'b1;
        if (popOk)  popped = modelQ.pop_front();
        if (pushOk) modelQ.push_back(wd);
        expValidB = pendValidB;
        if (pendValidB) lastB = pendDataB;
        pendValidB = popOk;
        pendDataB  = popped;
        expValidA  = popOk;
        if (popOk) lastA = popped;
    endtask

    task automatic checkInst(input string tag, input logic [4:0] cnt, input logic full,
                             input logic empty, input logic af, input logic ae,
                             input logic ovf, input logic unf, input logic vld,
                             input logic [7:0] data, input bit expVld,
                             input logic [7:0] expData);
        int n;
        n = modelQ.size();
        cmp({tag, " count"},        int'(cnt),  n);
        cmp({tag, " full"},         int'(full), int'(n == DEPTH));
        cmp({tag, " empty"},        int'(empty), int'(n == 0));
        cmp({tag, " almost_full"},  int'(af),   int'(n >= 12));
        cmp({tag, " almost_empty"}, int'(ae),   int'(n <= 4));
        cmp({tag, " overflow"},     int'(ovf),  int'(mOvf));
        cmp({tag, " underflow"},    int'(unf),  int'(mUnf));
        cmp({tag, " rvalid"},       int'(vld),  int'(expVld));
        cmp({tag, " rdata"},        int'(data), int'(expData));
    endtask

    task automatic checkOutput();
        checkInst("A", countA, fullA, emptyA, afA, aeA, ovfA, unfA, rvalidA, rdataA,
                  expValidA, lastA);
        checkInst("B", countB, fullB, emptyB, afB, aeB, ovfB, unfB, rvalidB, rdataB,
                  expValidB, lastB);
    endtask

    // Inputs change at the falling edge and the DUT samples them at the
    // rising edge. Outputs are checked at the next falling edge.
    task automatic applyStimulus(input logic we, input logic [7:0] wd, input logic re);
        wen   = we;
        wdata = wd;
        ren   = re;
        @(posedge clk);
        modelStep(we, wd, re);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic applyReset();
        @(negedge clk);
        nrst  = 1'b0;
        wen   = 1'b0;
        ren   = 1'b0;
        wdata = 8'd0;
        modelReset();
        #1;
        checkOutput();
        @(negedge clk);
        nrst = 1'b1;
    endtask

    initial begin
        nrst  = 1'b1;
        wen   = 1'b0;
        ren   = 1'b0;
        wdata = 8'd0;

        // Short directed table: forwarding, hold, and a pop while empty with a
        // simultaneous push (no bypass).
        vecs[0] = '{we:1'b1, wd:8'h11, re:1'b0, expCount:1, expEmpty:1'b0, expValid:1'b0, expData:8'h00, expUnf:1'b0};
        vecs[1] = '{we:1'b1, wd:8'h22, re:1'b1, expCount:1, expEmpty:1'b0, expValid:1'b1, expData:8'h11, expUnf:1'b0};
        vecs[2] = '{we:1'b0, wd:8'h00, re:1'b0, expCount:1, expEmpty:1'b0, expValid:1'b0, expData:8'h11, expUnf:1'b0};
        vecs[3] = '{we:1'b0, wd:8'h00, re:1'b1, expCount:0, expEmpty:1'b1, expValid:1'b1, expData:8'h22, expUnf:1'b0};
        vecs[4] = '{we:1'b1, wd:8'h05, re:1'b1, expCount:1, expEmpty:1'b0, expValid:1'b0, expData:8'h22, expUnf:1'b1};
        vecs[5] = '{we:1'b0, wd:8'h00, re:1'b1, expCount:0, expEmpty:1'b1, expValid:1'b1, expData:8'h05, expUnf:1'b1};

        applyReset();
        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].we, vecs[v].wd, vecs[v].re);
            cmp($sformatf("vec%0d count", v),     int'(countA),  vecs[v].expCount);
            cmp($sformatf("vec%0d empty", v),     int'(emptyA),  int'(vecs[v].expEmpty));
            cmp($sformatf("vec%0d rvalid", v),    int'(rvalidA), int'(vecs[v].expValid));
            cmp($sformatf("vec%0d rdata", v),     int'(rdataA),  int'(vecs[v].expData));
            cmp($sformatf("vec%0d underflow", v), int'(unfA),    int'(vecs[v].expUnf));
        end

        // Fill to full with 70,72..100, then push once more, then drain.
        applyReset();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(70 + 2 * i), 1'b0);
            cmp($sformatf("fill%0d almost_full", i), int'(afA), int'(i + 1 >= 12));
        end
        cmp("full after 16", int'(fullA), 1);
        cmp("count after 16", int'(countA), 16);
        applyStimulus(1'b1, 8'd200, 1'b0);
        cmp("overflow on 17th", int'(ovfA), 1);
        cmp("count after 17th", int'(countA), 16);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 8'd0, 1'b1);
            cmp($sformatf("drain%0d rvalid", i), int'(rvalidA), 1);
            cmp($sformatf("drain%0d rdata", i), int'(rdataA), 70 + 2 * i);
        end
        applyStimulus(1'b0, 8'd0, 1'b0);
        cmp("empty after drain", int'(emptyA), 1);
        cmp("B last rvalid", int'(rvalidB), 1);
        cmp("B last rdata", int'(rdataB), 100);

        // Steady push+pop at count 8 across three pointer wraps.
        applyReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0);
        end
        for (int i = 0; i < 48; i++) begin
            applyStimulus(1'b1, 8'(8 + i), 1'b1);
            cmp($sformatf("stream%0d count", i), int'(countA), 8);
            cmp($sformatf("stream%0d rdata", i), int'(rdataA), i);
        end

        // Reset pulse while a pop is in flight at count 6.
        applyReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 8'(30 + i), 1'b0);
        end
        wen = 1'b0;
        ren = 1'b1;
        @(posedge clk);
        #2;
        nrst = 1'b0;
        modelReset();
        #1;
        checkOutput();
        @(negedge clk);
        ren = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'd0, 1'b0);
            cmp($sformatf("post-reset%0d rvalidA", i), int'(rvalidA), 0);
            cmp($sformatf("post-reset%0d rvalidB", i), int'(rvalidB), 0);
            cmp($sformatf("post-reset%0d count", i), int'(countA), 0);
        end

        // Randomised traffic. Push-heavy and pop-heavy phases alternate so
        // the run reaches both full and empty.
        applyReset();
        for (int k = 0; k < 800; k++) begin
            bit pushHeavy;
            pushHeavy = ((k / 100) % 2) == 0;
            applyStimulus(
                ($urandom_range(0, 99) < (pushHeavy ? 75 : 25)) ? 1'b1 : 1'b0,
                8'($urandom),
                ($urandom_range(0, 99) < (pushHeavy ? 25 : 75)) ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
